// File: rtl/ahb_decode_ctrl.sv
// ahb_decode_ctrl
//
// Address-phase decoder and data-phase controller for a 4-slave AHB-Lite fabric.
// Also contains the built-in default slave. The default slave answers active
// transfers to unmapped addresses with the two-cycle ERROR response.
//
// Ports
//   HCLK           bus clock; all state updates on the rising edge
//   HRESET         synchronous, active-high reset
//   HADDR          master address (address phase)
//   HTRANS         master transfer type; bit 1 set means NONSEQ/SEQ (active)
//   MUX_HREADYOUT  HREADYOUT from the slave response multiplexor
//   MUX_HRESP      HRESP from the slave response multiplexor
//   HSEL1..HSEL4   combinational slave selects (address phase)
//   SEL            registered data-phase select to the response multiplexor
//   HREADY         bus-level ready, fed back to the master and all slaves
//   HRESP          bus-level response (1 = ERROR)
//   ERR_COUNT      saturating count of default-slave ERROR responses

module ahb_decode_ctrl #(
  parameter int unsigned             ADDR_HI = 31,
  parameter int unsigned             ADDR_LO = 28,
  parameter logic [ADDR_HI-ADDR_LO:0] BASE1  = 'h0,
  parameter logic [ADDR_HI-ADDR_LO:0] BASE2  = 'h1,
  parameter logic [ADDR_HI-ADDR_LO:0] BASE3  = 'h2,
  parameter logic [ADDR_HI-ADDR_LO:0] BASE4  = 'h3,
  parameter int unsigned             CNT_W   = 8
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             MUX_HREADYOUT,
  input  logic             MUX_HRESP,
  output logic             HSEL1,
  output logic             HSEL2,
  output logic             HSEL3,
  output logic             HSEL4,
  output logic [1:0]       SEL,
  output logic             HREADY,
  output logic             HRESP,
  output logic [CNT_W-1:0] ERR_COUNT
);

  localparam int unsigned FieldW = ADDR_HI - ADDR_LO + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StErr1 = 2'd1,
    StErr2 = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Address-phase decode
  // ---------------------------------------------------------------------------
  logic [FieldW-1:0] addr_field;
  logic [3:0]        match;
  logic [3:0]        hsel;
  logic [1:0]        sel_idx;
  logic              unmapped;
  logic              new_err;

  assign addr_field = HADDR[ADDR_HI:ADDR_LO];

  always_comb begin
    match[0] = (addr_field == BASE1);
    match[1] = (addr_field == BASE2);
    match[2] = (addr_field == BASE3);
    match[3] = (addr_field == BASE4);
  end

  // Overlapping bases resolve to the lowest slave number, so at most one HSEL is high.
  always_comb begin
    hsel    = 4'b0000;
    sel_idx = 2'd0;
    if (match[0]) begin
      hsel[0] = 1'b1;
      sel_idx = 2'd0;
    end else if (match[1]) begin
      hsel[1] = 1'b1;
      sel_idx = 2'd1;
    end else if (match[2]) begin
      hsel[2] = 1'b1;
      sel_idx = 2'd2;
    end else if (match[3]) begin
      hsel[3] = 1'b1;
      sel_idx = 2'd3;
    end
  end

  assign unmapped = ~|match;
  assign new_err  = unmapped & HTRANS[1];

  assign HSEL1 = hsel[0];
  assign HSEL2 = hsel[1];
  assign HSEL3 = hsel[2];
  assign HSEL4 = hsel[3];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             dflt_q, dflt_d;
  logic             err_req_q, err_req_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             hready;
  logic             hresp;

  // ---------------------------------------------------------------------------
  // Bus-level response mux
  // ---------------------------------------------------------------------------
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    unique case (state_q)
      StErr1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      StErr2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default: begin
        if (dflt_q) begin
          // Unmapped IDLE/BUSY data phase: zero-wait OKAY from the default slave.
          hready = 1'b1;
          hresp  = 1'b0;
        end else begin
          hready = MUX_HREADYOUT;
          hresp  = MUX_HRESP;
        end
      end
    endcase
  end

  assign HREADY = hready;
  assign HRESP  = hresp;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d     = sel_q;
    dflt_d    = dflt_q;
    err_req_d = err_req_q;
    // The data-phase owner changes only when the bus accepts an address phase.
    if (hready) begin
      sel_d     = sel_idx;
      dflt_d    = unmapped;
      err_req_d = new_err;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hready && err_req_d) begin
          state_d = StErr1;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      StErr2: begin
        // HREADY is high in ERR2, so the next address phase is accepted here.
        // Another active unmapped transfer chains straight into a new response.
        state_d = err_req_d ? StErr1 : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == StErr1) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StIdle;
      sel_q     <= 2'd0;
      dflt_q    <= 1'b1;
      err_req_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dflt_q    <= dflt_d;
      err_req_q <= err_req_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign SEL       = sel_q;
  assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_ahb_decode_ctrl.sv
// Testbench for ahb_decode_ctrl. A second instance with a 2-bit counter checks
// saturation. Expected responses are pushed into a scoreboard by the stimulus
// process. A monitor process pops them and compares them with the DUT outputs.

module tb_ahb_decode_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        mux_rdy;
  logic        mux_resp;

  logic        hsel1, hsel2, hsel3, hsel4;
  logic [1:0]  sel;
  logic        hready, hresp;
  logic [7:0]  err_count;

  logic        b_hsel1, b_hsel2, b_hsel3, b_hsel4;
  logic [1:0]  b_sel;
  logic        b_hready, b_hresp;
  logic [1:0]  b_err_count;

  ahb_decode_ctrl u_dut (
    .HCLK         (clk),
    .HRESET       (rst),
    .HADDR        (haddr),
    .HTRANS       (htrans),
    .MUX_HREADYOUT(mux_rdy),
    .MUX_HRESP    (mux_resp),
    .HSEL1        (hsel1),
    .HSEL2        (hsel2),
    .HSEL3        (hsel3),
    .HSEL4        (hsel4),
    .SEL          (sel),
    .HREADY       (hready),
    .HRESP        (hresp),
    .ERR_COUNT    (err_count)
  );

  ahb_decode_ctrl #(
    .CNT_W(2)
  ) u_dut_sat (
    .HCLK         (clk),
    .HRESET       (rst),
    .HADDR        (haddr),
    .HTRANS       (htrans),
    .MUX_HREADYOUT(mux_rdy),
    .MUX_HRESP    (mux_resp),
    .HSEL1        (b_hsel1),
    .HSEL2        (b_hsel2),
    .HSEL3        (b_hsel3),
    .HSEL4        (b_hsel4),
    .SEL          (b_sel),
    .HREADY       (b_hready),
    .HRESP        (b_hresp),
    .ERR_COUNT    (b_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          full;   // 0 while the model state is still unknown (HSEL only)
    logic [3:0]  hsel;
    logic        hready;
    logic        hresp;
    logic [1:0]  sel;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp;
  int n_fail;

  // Reference model: who owns the data phase and how many ERROR cycles remain.
  int  base_tab[4] = '{0, 1, 2, 3};
  bit  m_valid;
  int  m_owner;     // -1 = default slave, else slave index 0..3
  int  m_err_left;  // 2 = first ERROR cycle pending, 1 = second, 0 = none
  int  m_cnt;
  int  m_cnt2;

  function automatic int decode(input logic [31:0] a);
    int f;
    f = int'(a[31:28]);
    for (int i = 0; i < 4; i++) begin
      if (f == base_tab[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // One bus cycle: drive inputs just after the edge, record the expected outputs
  // for this cycle, then advance the model across the coming edge.
  task automatic cycle(input bit r, input logic [31:0] a, input logic [1:0] t,
                       input bit mr, input bit me);
    exp_t e;
    int   d;
    @(posedge clk);
    #1;
    rst      = r;
    haddr    = a;
    htrans   = t;
    mux_rdy  = mr;
    mux_resp = me;

    d      = decode(a);
    e.full = m_valid;
    e.hsel = (d < 0) ? 4'b0000 : 4'(1 << d);
    if (m_err_left == 2) begin
      e.hready = 1'b0;
      e.hresp  = 1'b1;
    end else if (m_err_left == 1) begin
      e.hready = 1'b1;
      e.hresp  = 1'b1;
    end else if (m_owner < 0) begin
      e.hready = 1'b1;
      e.hresp  = 1'b0;
    end else begin
      e.hready = mr;
      e.hresp  = me;
    end
    e.sel  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.cnt  = 8'(m_cnt);
    e.cnt2 = 2'(m_cnt2);
    sb_q.push_back(e);

    if (r) begin
      m_valid    = 1'b1;
      m_owner    = -1;
      m_err_left = 0;
      m_cnt      = 0;
      m_cnt2     = 0;
    end else if (m_valid) begin
      if (m_err_left == 2) begin
        m_err_left = 1;
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end else if (e.hready) begin
        m_owner    = d;
        m_err_left = (d < 0 && t[1]) ? 2 : 0;
      end
    end
  endtask

  // Monitor: the DUT presents a fresh set of outputs every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("hsel", {28'd0, hsel4, hsel3, hsel2, hsel1}, {28'd0, e.hsel});
      if (e.full) begin
        check("hready", {31'd0, hready}, {31'd0, e.hready});
        check("hresp", {31'd0, hresp}, {31'd0, e.hresp});
        check("sel", {30'd0, sel}, {30'd0, e.sel});
        check("err_count", {24'd0, err_count}, {24'd0, e.cnt});
        check("err_count_sat", {30'd0, b_err_count}, {30'd0, e.cnt2});
      end
    end
  end

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    m_valid    = 1'b0;
    m_owner    = -1;
    m_err_left = 0;
    m_cnt      = 0;
    m_cnt2     = 0;
    rst        = 1'b1;
    haddr      = 32'hF000_0000;
    htrans     = 2'b00;
    mux_rdy    = 1'b1;
    mux_resp   = 1'b0;

    // Reset for two cycles with an unmapped address.
    cycle(1, 32'hF000_0000, 2'b00, 1, 0);
    cycle(1, 32'hF000_0000, 2'b00, 1, 0);
    cycle(0, 32'hF000_0000, 2'b00, 1, 0);

    // Slave 3 transfer, then two wait states while the address moves on.
    cycle(0, 32'h2000_0010, 2'b10, 1, 0);
    cycle(0, 32'h0000_0000, 2'b10, 0, 0);
    cycle(0, 32'h0000_0000, 2'b10, 0, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);

    // Single unmapped NONSEQ: ERROR over two cycles.
    cycle(0, 32'h8000_0000, 2'b10, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);

    // Unmapped IDLE: zero-wait OKAY.
    cycle(0, 32'h8000_0000, 2'b00, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);

    // Back-to-back unmapped NONSEQs, the second accepted in ERR2.
    cycle(0, 32'h8000_0000, 2'b10, 1, 0);
    cycle(0, 32'h9000_0000, 2'b10, 1, 0);
    cycle(0, 32'h9000_0000, 2'b10, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);

    // Slave 2 ERROR passes through without counting.
    cycle(0, 32'h1000_0000, 2'b10, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 0, 1);
    cycle(0, 32'h0000_0000, 2'b00, 1, 1);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);

    // Reset during ERR1 drops the pending error.
    cycle(0, 32'hA000_0000, 2'b11, 1, 0);
    cycle(1, 32'h0000_0000, 2'b00, 1, 0);
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);

    // Five errors: the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      cycle(0, 32'hF000_0000, 2'b10, 1, 0);
      cycle(0, 32'h0000_0000, 2'b00, 1, 0);
      cycle(0, 32'h0000_0000, 2'b00, 1, 0);
    end
    cycle(0, 32'h0000_0000, 2'b00, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            {4'($urandom_range(0, 7)), 28'($urandom)},
            2'($urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0));
    end

    // Let the monitor drain the last entry.
    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
